// File: rtl/dbg_uart_if.sv
// Debug register-window bus between the UART bridge and the cpu debug port.
interface dbg_uart_if;
    logic [15:0] addr;
    logic [15:0] data;
    logic        r;
    logic [1:0]  w;
    logic [15:0] rdata;

    modport master (output addr, output data, output r, output w, input rdata);
    modport slave  (input addr, input data, input r, input w, output rdata);
endinterface

// File: rtl/dbg_uart.sv
// dbg_uart: fixed-rate 8N1 UART plus command sequencer driving the b16 debug window.
module dbg_uart #(
    parameter int unsigned DIV     = 217,
    parameter int unsigned TIMEOUT = 32'd1 << 20,
    parameter logic [15:0] DBGBASE = 16'hFFE0
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rxd,
    output logic       txd,
    dbg_uart_if.master bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [2:0] {S_IDLE, S_WHI, S_WLO, S_WBUS, S_RBUS, S_TXH, S_TXL} seq_t;

    // receiver
    logic             rx_s1, rx_s2, rx_armed;
    rx_t              rx_state, rx_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_sh;
    logic             rx_valid, rx_ferr;
    logic             rx_tick_c;

    // transmitter
    logic             tx_busy;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [8:0]       tx_sh;
    logic             tx_done_c;
    logic             tx_start_c;
    logic [7:0]       tx_byte_c;

    // sequencer
    seq_t             state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_c;
    logic             cmd_ok_c;
    logic [2:0]       idx_q, idx_nxt;
    logic [7:0]       hold_q, hold_nxt;
    logic [15:0]      addr_q, addr_nxt, data_q, data_nxt;
    logic             r_q, r_nxt;
    logic [1:0]       w_q, w_nxt;

    assign bus.addr = addr_q;
    assign bus.data = data_q;
    assign bus.r    = r_q;
    assign bus.w    = w_q;

    assign rx_tick_c = (rx_state == RX_START) ? (rx_cnt == CNT_W'(HALF - 1))
                                              : (rx_cnt == CNT_W'(DIV - 1));

    // RX next state: start detect, half-bit start recheck, 8 data bits, stop
    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_armed && !rx_s2) rx_nxt = RX_START;
            RX_START: if (rx_tick_c) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick_c && rx_bit == 3'd7) rx_nxt = RX_STOP;
            RX_STOP:  if (rx_tick_c) rx_nxt = RX_IDLE;
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    // RX state, synchronizer and datapath; sync flops reset low so a line
    // held low across reset never looks like a fresh falling edge
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_s1    <= 1'b0;
            rx_s2    <= 1'b0;
            rx_armed <= 1'b0;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_state <= rx_nxt;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                if (rx_s2) rx_armed <= 1'b1;
            end else begin
                rx_cnt <= rx_tick_c ? '0 : rx_cnt + CNT_W'(1);
                if (rx_tick_c && rx_state == RX_DATA) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                end
                if (rx_tick_c && rx_state == RX_STOP) begin
                    rx_valid <= rx_s2;
                    rx_ferr  <= !rx_s2;
                    rx_armed <= 1'b0;
                end
            end
        end
    end

    assign tx_done_c = tx_busy && (tx_cnt == CNT_W'(DIV - 1)) && (tx_bit == 4'd9);

    // TX shifter; a start request on the final stop clock chains without a gap
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '1;
        end else if (tx_start_c) begin
            txd     <= 1'b0;
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= {1'b1, tx_byte_c};
        end else if (tx_busy) begin
            if (tx_cnt == CNT_W'(DIV - 1)) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    txd     <= 1'b1;
                end else begin
                    txd    <= tx_sh[0];
                    tx_sh  <= {1'b1, tx_sh[8:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    assign tmo_c    = (tmo_cnt == TMO_W'(TIMEOUT));
    assign cmd_ok_c = rx_valid && (rx_sh[6:3] == 4'b0000);

    // inter-byte timeout, counting only while collecting write data
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tmo_cnt <= '0;
        end else if ((state == S_WHI || state == S_WLO) && !rx_valid && !tmo_c) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // sequencer state and registered bus outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= S_IDLE;
            idx_q  <= '0;
            hold_q <= '0;
            addr_q <= DBGBASE;
            data_q <= '0;
            r_q    <= 1'b0;
            w_q    <= 2'b00;
        end else begin
            state  <= state_nxt;
            idx_q  <= idx_nxt;
            hold_q <= hold_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            r_q    <= r_nxt;
            w_q    <= w_nxt;
        end
    end

    // sequencer next state; a framing error always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_ok_c) state_nxt = rx_sh[7] ? S_WHI : S_RBUS;
            S_WHI:  if (tmo_c) state_nxt = S_IDLE; else if (rx_valid) state_nxt = S_WLO;
            S_WLO:  if (tmo_c) state_nxt = S_IDLE; else if (rx_valid) state_nxt = S_WBUS;
            S_WBUS: state_nxt = S_IDLE;
            S_RBUS: state_nxt = S_TXH;
            S_TXH:  if (tx_done_c) state_nxt = S_TXL;
            S_TXL:  if (tx_done_c) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (rx_ferr) state_nxt = S_IDLE;
    end

    // sequencer outputs: strobes and addr land together one clock after the last byte
    always_comb begin
        idx_nxt    = idx_q;
        hold_nxt   = hold_q;
        addr_nxt   = addr_q;
        data_nxt   = data_q;
        r_nxt      = 1'b0;
        w_nxt      = 2'b00;
        tx_start_c = 1'b0;
        tx_byte_c  = 8'h00;
        case (state)
            S_IDLE: begin
                if (cmd_ok_c) begin
                    idx_nxt = rx_sh[2:0];
                    if (!rx_sh[7]) begin
                        r_nxt    = 1'b1;
                        addr_nxt = DBGBASE | {12'h000, rx_sh[2:0], 1'b0};
                    end
                end
            end
            S_WHI: if (rx_valid && !tmo_c) data_nxt[15:8] = rx_sh;
            S_WLO: begin
                if (rx_valid && !tmo_c) begin
                    data_nxt[7:0] = rx_sh;
                    w_nxt         = 2'b11;
                    addr_nxt      = DBGBASE | {12'h000, idx_q, 1'b0};
                end
            end
            S_RBUS: begin
                tx_start_c = 1'b1;
                tx_byte_c  = bus.rdata[15:8];
                hold_nxt   = bus.rdata[7:0];
            end
            S_TXH: begin
                if (tx_done_c) begin
                    tx_start_c = 1'b1;
                    tx_byte_c  = hold_q;
                end
            end
            default: ;
        endcase
    end
endmodule
